fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of `instruction_memory`. It owns the program counter, drives `current_pc` into the memory, and captures the returned 9-bit instruction into a fetch register for the decoder. It handles start, stall, taken branches (with a wrong-path flush), halt detection and PC wrap-around. It also exposes a retired-fetch counter for the testbench.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, captures memory output into a fetch register.
// Latency: one cycle from current_pc to fetched_instruction/fetched_pc; taken branch costs one bubble.
// Backpressure: stall freezes PC and fetch register; branch_taken and start override stall.
module fetch_unit #(
    parameter logic [31:0] START_PC   = 32'd0,
    parameter int unsigned PC_LIMIT   = 4096,
    parameter logic [8:0]  HALT_INSTR = 9'b111111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [8:0]  instruction_in,
    output logic [31:0] current_pc,
    output logic [8:0]  fetched_instruction,
    output logic [31:0] fetched_pc,
    output logic        fetch_valid,
    output logic        done,
    output logic        wrap_flag,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [8:0]  instr_q, instr_d;
    logic [31:0] fpc_q, fpc_d;
    logic        fvld_q, fvld_d;
    logic        wrap_q, wrap_d;
    logic [31:0] cnt_q, cnt_d;
    logic        at_last;

    assign at_last = (pc_q == 32'(PC_LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            instr_q <= '0;
            fpc_q   <= '0;
            fvld_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
            fvld_q  <= fvld_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fpc_d   = fpc_q;
        fvld_d  = fvld_q;
        wrap_d  = wrap_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                pc_d   = START_PC;
                fvld_d = 1'b0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (start) begin
                    pc_d   = START_PC;
                    fvld_d = 1'b0;
                end else if (branch_taken) begin
                    // Instruction at the old PC is wrong-path; drop it.
                    pc_d   = branch_target % 32'(PC_LIMIT);
                    fvld_d = 1'b0;
                end else if (!stall) begin
                    instr_d = instruction_in;
                    fpc_d   = pc_q;
                    fvld_d  = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                    if (instruction_in == HALT_INSTR) begin
                        state_d = HALTED;
                    end else if (at_last) begin
                        pc_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd1;
                    end
                end
            end
            HALTED: begin
                // Halt instruction is presented valid for exactly one cycle.
                fvld_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    wrap_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign current_pc          = pc_q;
    assign fetched_instruction = instr_q;
    assign fetched_pc          = fpc_q;
    assign fetch_valid         = fvld_q;
    assign done                = (state_q == HALTED);
    assign wrap_flag           = wrap_q;
    assign fetch_count         = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational 4096-entry memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [8:0]  instruction_in;
    logic [31:0] current_pc;
    logic [8:0]  fetched_instruction;
    logic [31:0] fetched_pc;
    logic        fetch_valid;
    logic        done;
    logic        wrap_flag;
    logic [31:0] fetch_count;

    logic [8:0] mem [0:4095];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instruction_in = mem[current_pc[11:0]];

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction_in(instruction_in), .current_pc(current_pc),
        .fetched_instruction(fetched_instruction), .fetched_pc(fetched_pc),
        .fetch_valid(fetch_valid), .done(done), .wrap_flag(wrap_flag),
        .fetch_count(fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (current_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", current_pc); end
        checks++; if (fetched_pc !== 32'd0) begin errors++; $display("FAIL reset_fpc: got %0d want 0", fetched_pc); end
        checks++; if (fetched_instruction !== 9'd0) begin errors++; $display("FAIL reset_instr: got %0h want 0", fetched_instruction); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", fetch_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b want 0", wrap_flag); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    endtask

    task automatic test_straight_line();
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL sl_first_bubble: got %0b want 0", fetch_valid); end
        checks++; if (current_pc !== 32'd0) begin errors++; $display("FAIL sl_start_pc: got %0d want 0", current_pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL sl_valid%0d: got %0b want 1", i, fetch_valid); end
            checks++; if (fetched_pc !== 32'(i)) begin errors++; $display("FAIL sl_fpc%0d: got %0d want %0d", i, fetched_pc, i); end
            checks++; if (fetched_instruction !== 9'(i + 1)) begin errors++; $display("FAIL sl_instr%0d: got %0h want %0h", i, fetched_instruction, i + 1); end
            checks++; if (fetch_count !== 32'(i + 1)) begin errors++; $display("FAIL sl_count%0d: got %0d want %0d", i, fetch_count, i + 1); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sl_done: got %0b want 1", done); end
        checks++; if (fetched_pc !== 32'd3) begin errors++; $display("FAIL sl_halt_fpc: got %0d want 3", fetched_pc); end
        checks++; if (fetched_instruction !== 9'h1FF) begin errors++; $display("FAIL sl_halt_instr: got %0h want 1ff", fetched_instruction); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL sl_halt_valid: got %0b want 1", fetch_valid); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL sl_halt_count: got %0d want 4", fetch_count); end
        checks++; if (current_pc !== 32'd3) begin errors++; $display("FAIL sl_halt_pc: got %0d want 3", current_pc); end
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd50;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL sl_halt_valid_drop: got %0b want 0", fetch_valid); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sl_done_hold: got %0b want 1", done); end
        checks++; if (current_pc !== 32'd3) begin errors++; $display("FAIL sl_pc_frozen: got %0d want 3", current_pc); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL sl_count_hold: got %0d want 4", fetch_count); end
    endtask

    task automatic test_restart_after_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rs_done: got %0b want 0", done); end
        checks++; if (current_pc !== 32'd0) begin errors++; $display("FAIL rs_pc: got %0d want 0", current_pc); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rs_valid: got %0b want 0", fetch_valid); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL rs_count_kept: got %0d want 4", fetch_count); end
        tick();
        checks++; if (fetched_pc !== 32'd0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL rs_resume: got fpc=%0d vld=%0b want fpc=0 vld=1", fetched_pc, fetch_valid); end
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL rs_count_inc: got %0d want 5", fetch_count); end
        mem[3] = 9'h004;
    endtask

    task automatic test_branch();
        tick();
        checks++; if (current_pc !== 32'd2) begin errors++; $display("FAIL br_pre_pc: got %0d want 2", current_pc); end
        branch_taken = 1'b1; branch_target = 32'd10;
        tick();
        branch_taken = 1'b0;
        checks++; if (current_pc !== 32'd10) begin errors++; $display("FAIL br_pc: got %0d want 10", current_pc); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL br_bubble: got %0b want 0", fetch_valid); end
        checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL br_count_flush: got %0d want 6", fetch_count); end
        tick();
        checks++; if (fetched_pc !== 32'd10 || fetch_valid !== 1'b1) begin errors++; $display("FAIL br_target: got fpc=%0d vld=%0b want fpc=10 vld=1", fetched_pc, fetch_valid); end
        checks++; if (fetched_instruction !== 9'd10) begin errors++; $display("FAIL br_instr: got %0h want a", fetched_instruction); end
        checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL br_count: got %0d want 7", fetch_count); end
    endtask

    task automatic test_stall_vs_branch();
        branch_taken = 1'b1; branch_target = 32'd4;
        tick();
        branch_taken = 1'b0;
        tick();
        checks++; if (current_pc !== 32'd5 || fetched_pc !== 32'd4) begin errors++; $display("FAIL st_setup: got pc=%0d fpc=%0d want pc=5 fpc=4", current_pc, fetched_pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (current_pc !== 32'd5 || fetched_pc !== 32'd4 || fetched_instruction !== 9'd4 || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL st_hold%0d: got pc=%0d fpc=%0d ins=%0h vld=%0b want pc=5 fpc=4 ins=4 vld=1", i, current_pc, fetched_pc, fetched_instruction, fetch_valid);
            end
            checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL st_count%0d: got %0d want 8", i, fetch_count); end
        end
        branch_taken = 1'b1; branch_target = 32'd20;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++; if (current_pc !== 32'd20) begin errors++; $display("FAIL st_branch_wins: got %0d want 20", current_pc); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL st_branch_flush: got %0b want 0", fetch_valid); end
        tick();
        checks++; if (fetched_pc !== 32'd20 || fetch_count !== 32'd9) begin errors++; $display("FAIL st_after: got fpc=%0d cnt=%0d want fpc=20 cnt=9", fetched_pc, fetch_count); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 32'd4095;
        tick();
        branch_taken = 1'b0;
        checks++; if (current_pc !== 32'd4095 || wrap_flag !== 1'b0) begin errors++; $display("FAIL wr_pre: got pc=%0d wrap=%0b want pc=4095 wrap=0", current_pc, wrap_flag); end
        tick();
        checks++; if (current_pc !== 32'd0) begin errors++; $display("FAIL wr_pc: got %0d want 0", current_pc); end
        checks++; if (fetched_pc !== 32'd4095 || fetched_instruction !== 9'd255) begin errors++; $display("FAIL wr_last: got fpc=%0d ins=%0h want fpc=4095 ins=ff", fetched_pc, fetched_instruction); end
        checks++; if (wrap_flag !== 1'b1) begin errors++; $display("FAIL wr_flag: got %0b want 1", wrap_flag); end
        tick();
        checks++; if (fetched_pc !== 32'd0 || fetched_instruction !== 9'd1) begin errors++; $display("FAIL wr_first: got fpc=%0d ins=%0h want fpc=0 ins=1", fetched_pc, fetched_instruction); end
        checks++; if (fetch_count !== 32'd11) begin errors++; $display("FAIL wr_count: got %0d want 11", fetch_count); end
        branch_taken = 1'b1; branch_target = 32'd4103;
        tick();
        branch_taken = 1'b0;
        checks++; if (current_pc !== 32'd7) begin errors++; $display("FAIL wr_mod_target: got %0d want 7", current_pc); end
        checks++; if (wrap_flag !== 1'b1) begin errors++; $display("FAIL wr_sticky: got %0b want 1", wrap_flag); end
    endtask

    task automatic test_reset_mid_run();
        tick();
        checks++; if (fetch_valid !== 1'b1 || fetch_count !== 32'd12) begin errors++; $display("FAIL rm_pre: got vld=%0b cnt=%0d want vld=1 cnt=12", fetch_valid, fetch_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (current_pc !== 32'd0 || fetched_pc !== 32'd0 || fetched_instruction !== 9'd0) begin errors++; $display("FAIL rm_async_regs: got pc=%0d fpc=%0d ins=%0h want 0 0 0", current_pc, fetched_pc, fetched_instruction); end
        checks++; if (fetch_valid !== 1'b0 || fetch_count !== 32'd0 || wrap_flag !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_async_flags: got vld=%0b cnt=%0d wrap=%0b done=%0b want 0", fetch_valid, fetch_count, wrap_flag, done); end
        tick();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (current_pc !== 32'd0 || fetch_valid !== 1'b0 || fetch_count !== 32'd0) begin errors++; $display("FAIL rm_idle: got pc=%0d vld=%0b cnt=%0d want 0 0 0", current_pc, fetch_valid, fetch_count); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (fetched_pc !== 32'd0 || fetch_valid !== 1'b1 || fetch_count !== 32'd1) begin errors++; $display("FAIL rm_restart: got fpc=%0d vld=%0b cnt=%0d want 0 1 1", fetched_pc, fetch_valid, fetch_count); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 9'(i & 255);
        test_reset();
        test_straight_line();
        test_restart_after_halt();
        test_branch();
        test_stall_vs_branch();
        test_wrap();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
